// File: rtl/cr_native_types.sv
// cr_native_types: shared rbus ring bundle carried node-to-node around the register ring.
package cr_native_types;
    localparam int RBUS_ADDR_BITS = 16;
    localparam int RBUS_DATA_BITS = 32;

    typedef struct packed {
        logic [RBUS_ADDR_BITS-1:0] addr;
        logic                      wr_strb;
        logic [RBUS_DATA_BITS-1:0] wr_data;
        logic                      rd_strb;
        logic [RBUS_DATA_BITS-1:0] rd_data;
        logic                      ack;
        logic                      err_ack;
    } rbus_ring_t;
endpackage

// File: rtl/cr_rbus_ring_master_pkg.sv
// cr_rbus_masterPKG: state/status encodings and defaults for the rbus ring master.
package cr_rbus_masterPKG;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} rbus_mst_state_e;
    typedef enum logic [1:0] {OK, ERR_ACK, UNCLAIMED, TIMEOUT} rbus_mst_status_e;
endpackage

// File: rtl/cr_rbus_ring_master_stats.sv
// cr_rbus_ring_master_stats: four saturating 16-bit event counters for the ring master.
module cr_rbus_ring_master_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_txn,
    input  logic        i_err,
    input  logic        i_to,
    input  logic        i_spur,
    output logic [15:0] o_txn_cnt,
    output logic [15:0] o_err_cnt,
    output logic [15:0] o_to_cnt,
    output logic [15:0] o_spur_cnt
);
    logic [15:0] r_txn, r_err, r_to, r_spur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn  <= '0;
            r_err  <= '0;
            r_to   <= '0;
            r_spur <= '0;
        end else begin
            r_txn  <= r_txn  + 16'(i_txn  && r_txn  != 16'hFFFF);
            r_err  <= r_err  + 16'(i_err  && r_err  != 16'hFFFF);
            r_to   <= r_to   + 16'(i_to   && r_to   != 16'hFFFF);
            r_spur <= r_spur + 16'(i_spur && r_spur != 16'hFFFF);
        end
    end

    assign o_txn_cnt  = r_txn;
    assign o_err_cnt  = r_err;
    assign o_to_cnt   = r_to;
    assign o_spur_cnt = r_spur;
endmodule

// File: rtl/cr_rbus_ring_master.sv
// cr_rbus_ring_master: head of the rbus ring; one outstanding read/write with ack/err/timeout.
// Optional saturating statistics counters under CR_RBUS_RING_MASTER_STATS_EN.
module cr_rbus_ring_master
    import cr_native_types::*;
    import cr_rbus_masterPKG::*;
#(
    parameter int N_RBUS_ADDR_BITS = RBUS_ADDR_BITS,
    parameter int N_RBUS_DATA_BITS = RBUS_DATA_BITS,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] cmd_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] cmd_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] rsp_rdata,
    output logic [1:0]                  rsp_status,
`ifdef CR_RBUS_RING_MASTER_STATS_EN
    output logic [15:0]                 stat_txn_cnt,
    output logic [15:0]                 stat_err_cnt,
    output logic [15:0]                 stat_to_cnt,
    output logic [15:0]                 stat_spur_cnt,
`endif
    output rbus_ring_t                  rbus_ring_o,
    input  rbus_ring_t                  rbus_ring_i
);
    rbus_mst_state_e               r_state, w_state_nxt;
    rbus_mst_status_e              r_status, w_status_nxt;
    logic                          r_wr;
    logic [N_RBUS_ADDR_BITS-1:0]   r_addr;
    logic [N_RBUS_DATA_BITS-1:0]   r_wdata, r_rdata, w_rdata_nxt;
    logic [15:0]                   r_cnt, w_cnt_nxt;
    logic                          w_cmd_hs;
    logic                          w_unused;

    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign cmd_ready = rst_n && r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_status = r_status;
    assign w_unused  = ^{rbus_ring_i.addr, rbus_ring_i.wr_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_status <= OK;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            r_rdata  <= w_rdata_nxt;
            r_cnt    <= w_cnt_nxt;
            if (w_cmd_hs) begin
                r_wr    <= cmd_wr;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
        end
    end

    // Ring input is only looked at in WAIT; everything else is discarded.
    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        w_rdata_nxt  = r_rdata;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE:  w_state_nxt = w_cmd_hs ? ISSUE : IDLE;
            ISSUE: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = '0;
            end
            WAIT: begin
                w_cnt_nxt = r_cnt + 16'd1;
                if (rbus_ring_i.err_ack || rbus_ring_i.ack || rbus_ring_i.wr_strb ||
                    rbus_ring_i.rd_strb || r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt  = RESP;
                    w_rdata_nxt  = (rbus_ring_i.ack && !rbus_ring_i.err_ack && !r_wr) ?
                                   rbus_ring_i.rd_data : '0;
                    w_status_nxt = rbus_ring_i.err_ack ? ERR_ACK :
                                   rbus_ring_i.ack ? OK :
                                   (rbus_ring_i.wr_strb || rbus_ring_i.rd_strb) ? UNCLAIMED :
                                   TIMEOUT;
                end
            end
            RESP:  w_state_nxt = rsp_ready ? IDLE : RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rbus_ring_o = '0;
        if (r_state == ISSUE || r_state == WAIT) begin
            rbus_ring_o.addr    = r_addr;
            rbus_ring_o.wr_data = r_wr ? r_wdata : '0;
        end
        if (r_state == ISSUE) begin
            rbus_ring_o.wr_strb = r_wr;
            rbus_ring_o.rd_strb = !r_wr;
        end
    end

`ifdef CR_RBUS_RING_MASTER_STATS_EN
    logic w_rsp_hs;
    assign w_rsp_hs = rsp_valid && rsp_ready;

    cr_rbus_ring_master_stats u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_txn     (w_rsp_hs),
        .i_err     (w_rsp_hs && (r_status == ERR_ACK || r_status == UNCLAIMED)),
        .i_to      (w_rsp_hs && r_status == TIMEOUT),
        .i_spur    ((rbus_ring_i.ack || rbus_ring_i.err_ack) && r_state != WAIT),
        .o_txn_cnt (stat_txn_cnt),
        .o_err_cnt (stat_err_cnt),
        .o_to_cnt  (stat_to_cnt),
        .o_spur_cnt(stat_spur_cnt)
    );
`endif
endmodule

// File: tb/tb_cr_rbus_ring_master.sv
// tb_cr_rbus_ring_master: directed + randomized bench with a transaction-level responder model.
module tb_cr_rbus_ring_master;
    import cr_native_types::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    rbus_ring_t  ring_o, ring_i;
`ifdef CR_RBUS_RING_MASTER_STATS_EN
    logic [15:0] stat_txn_cnt, stat_err_cnt, stat_to_cnt, stat_spur_cnt;
`endif

    int checks = 0, errors = 0;
    int m_txn = 0, m_err = 0, m_to = 0, m_spur = 0;

    always #5 clk = ~clk;

    cr_rbus_ring_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
`ifdef CR_RBUS_RING_MASTER_STATS_EN
        .stat_txn_cnt(stat_txn_cnt), .stat_err_cnt(stat_err_cnt),
        .stat_to_cnt(stat_to_cnt), .stat_spur_cnt(stat_spur_cnt),
`endif
        .rbus_ring_o(ring_o), .rbus_ring_i(ring_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef CR_RBUS_RING_MASTER_STATS_EN
        chk("stat_txn", 64'(stat_txn_cnt), 64'(m_txn));
        chk("stat_err", 64'(stat_err_cnt), 64'(m_err));
        chk("stat_to", 64'(stat_to_cnt), 64'(m_to));
        chk("stat_spur", 64'(stat_spur_cnt), 64'(m_spur));
`endif
    endtask

    // mode: 0 ack, 1 err_ack, 2 ack+err_ack, 3 strobe returned unclaimed, 4 silent (timeout)
    // d: WAIT cycle on which the responder answers; bp: cycles of rsp backpressure;
    // sj: backpressure cycle on which a stray ack is injected (-1 none)
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input int mode, input int d, input int bp, input int sj);
        logic [31:0] rdv;
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        int n, i;
        rdv    = $urandom;
        exp_st = mode == 0 ? 2'd0 : mode <= 2 ? 2'd1 : mode == 3 ? 2'd2 : 2'd3;
        exp_rd = (mode == 0 && !wr) ? rdv : 32'd0;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_wdata = $urandom; cmd_wr = 1'($urandom);
        chk("issue_strb", {62'd0, ring_o.wr_strb, ring_o.rd_strb}, {62'd0, wr, !wr});
        chk("issue_addr", 64'(ring_o.addr), 64'(addr));
        chk("issue_wdata", 64'(ring_o.wr_data), wr ? 64'(wdata) : 64'd0);
        chk("issue_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("wait_strb", {62'd0, ring_o.wr_strb, ring_o.rd_strb}, 64'd0);
        chk("wait_addr", 64'(ring_o.addr), 64'(addr));
        chk("wait_wdata", 64'(ring_o.wr_data), wr ? 64'(wdata) : 64'd0);
        chk("wait_fwd", {61'd0, ring_o.ack, ring_o.err_ack, |ring_o.rd_data}, 64'd0);
        for (i = 0; i < 100; i++) begin
            if (i > 0 && rsp_valid) break;
            ring_i = '0;
            if (i == d && mode != 4) begin
                ring_i.rd_data = rdv;
                ring_i.ack     = mode == 0 || mode == 2;
                ring_i.err_ack = mode == 1 || mode == 2;
                ring_i.wr_strb = mode == 3 && wr;
                ring_i.rd_strb = mode == 3 && !wr;
                ring_i.addr    = addr;
            end
            @(negedge clk);
        end
        ring_i = '0;
        chk("rsp_latency", 64'(i), mode == 4 ? 64'(TO) : 64'(d + 1));
        for (int j = 0; j < bp; j++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_status", 64'(rsp_status), 64'(exp_st));
            chk("bp_rdata", 64'(rsp_rdata), 64'(exp_rd));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_no_strb", {62'd0, ring_o.wr_strb, ring_o.rd_strb}, 64'd0);
            cmd_valid = 1'b1;
            if (j == sj) begin
                ring_i.ack = 1'b1;
                m_spur++;
            end
            @(negedge clk);
            ring_i = '0;
        end
        cmd_valid = 1'b0;
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_status", 64'(rsp_status), 64'(exp_st));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("resp_addr0", 64'(ring_o.addr), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_txn++;
        if (exp_st == 2'd1 || exp_st == 2'd2) m_err++;
        if (exp_st == 2'd3) m_to++;
        chk("post_valid", 64'(rsp_valid), 64'd0);
        chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_ring_zero", 64'(ring_o == '0), 64'd1);
        chk_stats();
    endtask

    initial begin
        ring_i = '0;
        #12;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_ring_zero", 64'(ring_o == '0), 64'd1);
        chk("rst_rsp", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
        chk("rst_status", 64'(rsp_status), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk_stats();

        run_txn(1'b1, 16'h0040, 32'hA5A5_0001, 0, 2, 0, -1);
        run_txn(1'b0, 16'h0044, 32'h0, 0, 0, 0, -1);
        run_txn(1'b0, 16'h0F00, 32'h0, 3, 1, 0, -1);
        run_txn(1'b1, 16'h0048, 32'hDEAD_BEEF, 1, 3, 0, -1);
        run_txn(1'b0, 16'h004C, 32'h0, 2, 0, 0, -1);
        run_txn(1'b0, 16'h0050, 32'h0, 4, 0, 8, 5);
        run_txn(1'b0, 16'h0054, 32'h0, 0, 4, 10, -1);
        run_txn(1'b1, 16'h0058, 32'h0123_4567, 0, 0, 0, -1);

        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0060;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ring_zero", 64'(ring_o == '0), 64'd1);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_rsp", {30'd0, rsp_status, rsp_rdata}, 64'd0);
        m_txn = 0; m_err = 0; m_to = 0; m_spur = 0;
        repeat (2) @(negedge clk);
        chk("mid_rst_hold_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_stats();
        run_txn(1'b0, 16'h0064, 32'h0, 0, 1, 0, -1);

        for (int k = 0; k < 40; k++) begin
            int bp, sj;
            bp = int'($urandom % 4);
            sj = (bp > 0 && $urandom % 2 == 1) ? int'($urandom % bp) : -1;
            run_txn(1'($urandom), 16'($urandom), $urandom, int'($urandom % 5),
                    int'($urandom % 8), bp, sj);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
